// File: rtl/parity_rr_pkg.sv
// Shared types and helpers for the parity round-robin scheduler: FSM state,
// the fixed XOR5 operand width and the cyclic first-valid picker.
package parity_rr_pkg;

  localparam int DW_FIXED     = 5;
  localparam int NREQ_DEFAULT = 4;
  localparam int NREQ_MAX     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pick_t;

  // First valid requester at or after ptr, walking cyclically over nreq slots.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                    input logic [2:0]          ptr,
                                    input int                  nreq);
    pick_t r;
    int    j;
    r = '0;
    for (int i = 0; i < NREQ_MAX; i++) begin
      j = (int'(ptr) + i) % nreq;
      if (i < nreq && !r.hit && valid[3'(j)]) begin
        r.hit = 1'b1;
        r.idx = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/parity_rr_scheduler_parity5_unit.sv
// The shared resource: a purely combinational 5-input XOR (odd-ones detector).
module parity5_unit (
  input  logic [4:0] i_in,
  output logic       o_out
);

  assign o_out = ^i_in;

endmodule

// File: rtl/parity_rr_scheduler.sv
// Round-robin scheduler sharing one XOR5 unit among NREQ valid/ready requesters.
// Optional completed-response counter enabled by defining PARITY_RR_STATS_EN.
module parity_rr_scheduler
  import parity_rr_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ),
  parameter int DW   = DW_FIXED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_parity,
  output logic [IDW-1:0]    resp_id
`ifdef PARITY_RR_STATS_EN
  ,
  output logic [15:0]       stat_count
`endif
);

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_resp_id;
  logic           r_resp_parity;

  logic           w_done;
  logic           w_can_grant;
  logic           w_grant;
  logic [IDW-1:0] w_ptr_next;
  logic [IDW-1:0] w_ptr_eff;
  logic [IDW-1:0] w_gnt_idx;
  pick_t          w_pick;
  logic [DW-1:0]  w_operand;
  logic           w_parity;

  assign w_done     = (r_state == HOLD) && resp_ready;
  assign w_ptr_next = (r_resp_id == IDW'(NREQ-1)) ? '0 : r_resp_id + IDW'(1);
  // A same-cycle regrant on completion must already see the advanced pointer.
  assign w_ptr_eff  = w_done ? w_ptr_next : r_rr_ptr;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign w_can_grant = rst_n && ((r_state == IDLE) || w_done);
  assign w_pick      = rr_pick(NREQ_MAX'(req_valid), 3'(w_ptr_eff), NREQ);
  assign w_grant     = w_can_grant && w_pick.hit;
  assign w_gnt_idx   = IDW'(w_pick.idx);

  always_comb begin
    // NOTE: default first so every path assigns w_operand; otherwise a latch is inferred.
    w_operand = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_gnt_idx) w_operand = req_data[i*DW +: DW];
    end
  end

  parity5_unit u_parity5 (
    .i_in  (w_operand),
    .o_out (w_parity)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_next = HOLD;
      HOLD:    if (resp_ready) w_state_next = w_grant ? HOLD : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = (r_state == HOLD);
    if (w_grant) req_ready = NREQ'(1) << w_gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= '0;
      r_resp_id     <= '0;
      r_resp_parity <= 1'b0;
    end else begin
      if (w_done)  r_rr_ptr <= w_ptr_next;
      if (w_grant) begin
        r_resp_id     <= w_gnt_idx;
        r_resp_parity <= w_parity;
      end
    end
  end

  assign resp_id     = r_resp_id;
  assign resp_parity = r_resp_parity;

`ifdef PARITY_RR_STATS_EN
  logic [15:0] r_stat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_stat_count <= '0;
    else if (w_done && r_stat_count != 16'hFFFF) r_stat_count <= r_stat_count + 16'd1;
  end

  assign stat_count = r_stat_count;
`endif

endmodule

// File: tb/tb_parity_rr_scheduler.sv
// Testbench for parity_rr_scheduler: vector table, directed corner sequences and
// a negedge monitor with reference arbiter model and result scoreboard.
module tb_parity_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 5;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_parity;
  logic [IDW-1:0]    resp_id;
`ifdef PARITY_RR_STATS_EN
  logic [15:0]       stat_count;
`endif

  parity_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_parity (resp_parity),
    .resp_id     (resp_id)
`ifdef PARITY_RR_STATS_EN
    ,
    .stat_count  (stat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: expected result of an accepted operand.
  typedef struct {
    logic par;
    int   id;
  } sb_t;
  sb_t sb[$];

  // Reference arbiter model, evaluated once per cycle on the falling edge.
  logic m_busy = 1'b0;
  int   m_ptr  = 0;
  int   m_id   = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    sb_t             e;
    int              g;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      sb.delete();
    end else begin
      check("mon_resp_valid", 32'(resp_valid), 32'(m_busy));
      if (m_busy && resp_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_parity", 32'(resp_parity), 32'(e.par));
          check("sb_id", 32'(resp_id), 32'(e.id));
        end
        m_ptr  = (m_id + 1) % NREQ;
        m_busy = 1'b0;
      end
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int i = 0; i < NREQ; i++) begin
          if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("mon_req_ready", 32'(req_ready), 32'(exp_rdy));
      if (g >= 0) begin
        e.par = ^req_data[g*DW +: DW];
        e.id  = g;
        sb.push_back(e);
        m_busy = 1'b1;
        m_id   = g;
      end
    end
  end

  typedef struct {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic [NREQ-1:0] exp_ready;
    logic           exp_parity;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [DW-1:0] hold_data;
    int            order[5];

    vecs[0] = '{data: 5'b10110, id: 2'd0, exp_ready: 4'b0001, exp_parity: 1'b1};
    vecs[1] = '{data: 5'b00000, id: 2'd1, exp_ready: 4'b0010, exp_parity: 1'b0};
    vecs[2] = '{data: 5'b11111, id: 2'd2, exp_ready: 4'b0100, exp_parity: 1'b1};
    vecs[3] = '{data: 5'b10001, id: 2'd3, exp_ready: 4'b1000, exp_parity: 1'b0};
    vecs[4] = '{data: 5'b01000, id: 2'd0, exp_ready: 4'b0001, exp_parity: 1'b1};
    vecs[5] = '{data: 5'b11011, id: 2'd3, exp_ready: 4'b1000, exp_parity: 1'b0};
    order   = '{0, 1, 2, 3, 0};

    // Reset state, with all requesters asserting valid.
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = 20'h5A5A5;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_parity", 32'(resp_parity), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
`ifdef PARITY_RR_STATS_EN
    check("rst_stat_count", 32'(stat_count), 32'd0);
`endif
    req_valid = '0;
    rst_n     = 1'b1;

    // Single-request vectors.
    foreach (vecs[k]) begin
      @(posedge clk); #1;
      req_data                    = 20'($urandom);
      req_data[vecs[k].id*DW +: DW] = vecs[k].data;
      req_valid                   = vecs[k].exp_ready;
      resp_ready                  = 1'b0;
      @(negedge clk);
      check("vec_req_ready", 32'(req_ready), 32'(vecs[k].exp_ready));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("vec_resp_valid", 32'(resp_valid), 32'd1);
      check("vec_resp_parity", 32'(resp_parity), 32'(vecs[k].exp_parity));
      check("vec_resp_id", 32'(resp_id), 32'(vecs[k].id));
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end

    // All valid with resp_ready held: grants 0,1,2,3,0 back-to-back.
    req_data   = 20'b10110_00111_11100_01011;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_order", 32'(req_ready), 32'(4'b0001 << order[k]));
      @(posedge clk); #1;
    end

    // Backpressure for 3 cycles while holding the result of requester 0.
    resp_ready = 1'b0;
    hold_data  = req_data[0 +: DW];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_id", 32'(resp_id), 32'd0);
      check("bp_resp_parity", 32'(resp_parity), 32'(^hold_data));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Wrap-around: serve 2 so the pointer sits at 3, then 1001 -> 3 then 0.
    req_valid = 4'b0100;
    @(negedge clk);
    check("wrap_prep_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    @(negedge clk);
    check("wrap_grant3", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset mid-HOLD: resp_valid drops at once, pointer returns to 0.
    req_valid = 4'b0010;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("rstmid_hold", 32'(resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    check("rstmid_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk); @(negedge clk); @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rstmid_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

`ifdef PARITY_RR_STATS_EN
    // Saturation of the completed-response counter.
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("stat_saturated", 32'(stat_count), 32'hFFFF);
    @(posedge clk); #1;
    check("stat_hold_ffff", 32'(stat_count), 32'hFFFF);
    req_valid = '0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
`endif

    repeat (3) @(posedge clk);
    check("end_idle", 32'(resp_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
